// File: rtl/tx_send_scheduler_pkg.sv
// Shared types and default configuration for the TX send scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_send_scheduler_pkg;

  localparam int DEF_ADDR_W         = 25;
  localparam int DEF_GAP_CYCLES     = 80;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  // One counter serves both the inter-packet gap and the completion timeout.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

endpackage

// File: rtl/tx_send_scheduler_fifo.sv
// Descriptor queue: synchronous FIFO, WIDTH bits wide, DEPTH (power of two) entries.
// Latency: a pushed word is visible at head one cycle later (when it is the oldest entry).
// Backpressure: push is dropped while full (pop in the same cycle does not make room); pop at empty is ignored.
// Ports: clk_50/rst_n clock and async active-low reset; push/push_data write side;
//        pop read side; head = oldest entry; level = occupancy; full = level==DEPTH.
module tx_send_scheduler_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic                     clk_50,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk_50) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tx_send_scheduler.sv
// TX send scheduler: queues DDR packet addresses and issues them one at a time to the TX engine, with an idle gap after each packet.
// Latency: a descriptor pushed into an empty queue while enabled is issued (cmd_send) two cycles after the push edge.
// Backpressure: desc_ready drops when the queue holds DEPTH entries; the engine paces issue through tx_done plus GAP_CYCLES.
// Ports: clk_50/rst_n clock and async active-low reset; enable gates issue; desc_addr/desc_valid/desc_ready push side;
//        start_ram_addr/cmd_send/tx_done engine handshake; level, sent_count, timeout_err/err_clr status.
// Option: define TX_SEND_SCHEDULER_TIMEOUT_EN to bound WAIT_DONE by TIMEOUT_CYCLES and drive timeout_err.
module tx_send_scheduler
  import tx_send_scheduler_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk_50,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        desc_addr,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  output logic [ADDR_W-1:0]        start_ram_addr,
  output logic                     cmd_send,
  input  logic                     tx_done,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              sent_count,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              fifo_full;
  logic [ADDR_W-1:0] fifo_head;
  logic              pop;
  logic              done_ok;
`ifdef TX_SEND_SCHEDULER_TIMEOUT_EN
  logic              tmo_hit;
`endif

  tx_send_scheduler_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .push      (desc_valid),
    .push_data (desc_addr),
    .pop       (pop),
    .head      (fifo_head),
    .level     (level),
    .full      (fifo_full)
  );

  // Derived from registered occupancy only, so no combinational path from desc_valid.
  assign desc_ready = !fifo_full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cmd_send  = 1'b0;
    done_ok   = 1'b0;
`ifdef TX_SEND_SCHEDULER_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (enable && (level != '0)) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd_send  = 1'b1;
        pop       = 1'b1;
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A completion arriving on the timeout cycle counts as a normal completion.
        if (tx_done) begin
          done_ok   = 1'b1;
          state_nxt = ST_GAP;
        end
`ifdef TX_SEND_SCHEDULER_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_GAP;
        end
`endif
      end
      ST_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The counter restarts on every state change, so it reads "cycles spent in
  // the current state" for both GAP and WAIT_DONE.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
`ifdef TX_SEND_SCHEDULER_TIMEOUT_EN
    end else if ((state == ST_GAP) || (state == ST_WAIT_DONE)) begin
`else
    end else if (state == ST_GAP) begin
`endif
      cnt <= cnt + 1'b1;
    end
  end

  // Latch the head on entry to ISSUE so the address is stable for the whole
  // cmd_send cycle and held until the next issue.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      start_ram_addr <= '0;
    end else if ((state == ST_IDLE) && (state_nxt == ST_ISSUE)) begin
      start_ram_addr <= fifo_head;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sent_count <= '0;
    end else if (done_ok) begin
      sent_count <= sent_count + 16'd1;
    end
  end

`ifdef TX_SEND_SCHEDULER_TIMEOUT_EN
  // A timeout in the same cycle as err_clr wins.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end
`else
  assign timeout_err = 1'b0;

  // err_clr and TIMEOUT_CYCLES have no function in this build.
  logic unused_cfg;
  assign unused_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule
